// File: rtl/ysyx_23060180_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060180_mem_responder
//  Purpose  : Word-addressed memory responder with a byte-masked write port
//             and a 0..4 cycle read pipeline. Defining MEM_RESP_ERR_EN adds
//             range checking: out-of-range reads return 32'hDEADBEEF with
//             resp_err set, and out-of-range writes are dropped.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_23060180_mem_responder #(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE      = 32'h8000_0000,
    parameter int          LATENCY   = 0,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic [31:0] mem_raddr,
    output logic [31:0] mem_rdata,
    output logic        mem_rvalid,
    input  logic        mem_wr,
    input  logic [31:0] mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic        resp_err,
    output logic [31:0] rd_cnt
);

    localparam int          c_AW       = $clog2(DEPTH);
    localparam logic [31:0] c_ERR_WORD = 32'hDEAD_BEEF;

    logic [31:0]     r_mem [DEPTH];
    logic [31:0]     r_rd_cnt;

    logic [31:0]     w_roff;
    logic [31:0]     w_woff;
    logic [c_AW-1:0] w_ridx;
    logic [c_AW-1:0] w_widx;
    logic            w_rin;
    logic            w_win;
    logic [31:0]     w_rword;
    logic            w_s0_vld;
    logic [31:0]     w_s0_data;
    logic            w_s0_err;
    logic            w_we;
    logic            w_unused_ok;

    // Offsets from BASE: index is the low word bits, range check is "no high bits".
    assign w_roff  = mem_raddr - BASE;
    assign w_woff  = mem_waddr - BASE;
    assign w_ridx  = w_roff[c_AW+1:2];
    assign w_widx  = w_woff[c_AW+1:2];
    assign w_rin   = (w_roff[31:c_AW+2] == '0);
    assign w_win   = (w_woff[31:c_AW+2] == '0);
    assign w_rword = r_mem[w_ridx];

    assign w_unused_ok = ^{w_roff[1:0], w_woff[1:0], w_rin, w_win};

    assign w_s0_vld = mem_rd;
`ifdef MEM_RESP_ERR_EN
    assign w_s0_data = w_rin ? w_rword : c_ERR_WORD;
    assign w_s0_err  = ~w_rin;
    assign w_we      = mem_wr & ~rst & w_win;
`else
    assign w_s0_data = w_rword;
    assign w_s0_err  = 1'b0;
    assign w_we      = mem_wr & ~rst;
`endif

    // Array has no reset; stores landing in a reset cycle are suppressed via w_we.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) begin
                    r_mem[w_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt <= '0;
        end else if (mem_rd) begin
            r_rd_cnt <= r_rd_cnt + 32'd1;
        end
    end

    assign rd_cnt = r_rd_cnt;

    generate
        if (LATENCY == 0) begin : g_comb
            assign mem_rvalid = w_s0_vld;
            assign mem_rdata  = w_s0_vld ? w_s0_data : '0;
            assign resp_err   = w_s0_vld & w_s0_err;
        end else begin : g_pipe
            logic [LATENCY-1:0] r_vld;
            logic [LATENCY-1:0] r_err;
            logic [31:0]        r_data [LATENCY];

            // Data is captured at issue, so later stores never alter an in-flight response.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld <= '0;
                    r_err <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        r_data[i] <= '0;
                    end
                end else begin
                    r_vld[0]  <= w_s0_vld;
                    r_err[0]  <= w_s0_vld & w_s0_err;
                    r_data[0] <= w_s0_vld ? w_s0_data : '0;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_vld[i]  <= r_vld[i-1];
                        r_err[i]  <= r_err[i-1];
                        r_data[i] <= r_data[i-1];
                    end
                end
            end

            assign mem_rvalid = r_vld[LATENCY-1];
            assign mem_rdata  = r_vld[LATENCY-1] ? r_data[LATENCY-1] : '0;
            assign resp_err   = r_vld[LATENCY-1] & r_err[LATENCY-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060180_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_23060180_mem_responder
//  Purpose  : Directed bench for the memory responder; three instances
//             (LATENCY 0, 2, 3) share one set of request inputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_23060180_mem_responder;

`ifdef MEM_RESP_ERR_EN
    localparam logic [31:0] c_OOR_DATA = 32'hDEAD_BEEF;
    localparam logic        c_OOR_ERR  = 1'b1;
    localparam logic [31:0] c_W1_DATA  = 32'h0BAD_F00D;
`else
    localparam logic [31:0] c_OOR_DATA = 32'h0010_0093;
    localparam logic        c_OOR_ERR  = 1'b0;
    localparam logic [31:0] c_W1_DATA  = 32'h5566_7788;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_rd = 1'b0;
    logic [31:0] mem_raddr = '0;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_waddr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;

    logic [31:0] l0_rdata, l2_rdata, l3_rdata;
    logic        l0_rvalid, l2_rvalid, l3_rvalid;
    logic        l0_err, l2_err, l3_err;
    logic [31:0] l0_cnt, l2_cnt, l3_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_cnt  = '0;

    always #5 clk = ~clk;

    ysyx_23060180_mem_responder #(.LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
        .mem_rdata(l0_rdata), .mem_rvalid(l0_rvalid), .mem_wr(mem_wr),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .resp_err(l0_err), .rd_cnt(l0_cnt)
    );

    ysyx_23060180_mem_responder #(.LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
        .mem_rdata(l2_rdata), .mem_rvalid(l2_rvalid), .mem_wr(mem_wr),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .resp_err(l2_err), .rd_cnt(l2_cnt)
    );

    ysyx_23060180_mem_responder #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
        .mem_rdata(l3_rdata), .mem_rvalid(l3_rvalid), .mem_wr(mem_wr),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .resp_err(l3_err), .rd_cnt(l3_cnt)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic [31:0] raddr;
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        exp_vld;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [31:0] raddr, input logic wr,
                         input logic [31:0] waddr, input logic [31:0] wdata,
                         input logic [3:0] wmask);
        mem_rd    = rd;
        mem_raddr = raddr;
        mem_wr    = wr;
        mem_waddr = waddr;
        mem_wdata = wdata;
        mem_wmask = wmask;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, 4'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        //             name              rd  raddr          wr  waddr          wdata          mask  vld  data           err
        vecs[0]  = '{"wr_w0",          0, 32'h8000_0000, 1, 32'h8000_0000, 32'h0010_0093, 4'hF, 0, 32'h0,         0};
        vecs[1]  = '{"rd_w0",          1, 32'h8000_0000, 0, 32'h0,         32'h0,         4'h0, 1, 32'h0010_0093, 0};
        vecs[2]  = '{"wr_w1",          0, 32'h0,         1, 32'h8000_0004, 32'h0BAD_F00D, 4'hF, 0, 32'h0,         0};
        vecs[3]  = '{"wr_w4_ones",     0, 32'h0,         1, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         0};
        vecs[4]  = '{"rd_same_cyc_wr", 1, 32'h8000_0010, 1, 32'h8000_0010, 32'h1122_3344, 4'h5, 1, 32'hFFFF_FFFF, 0};
        vecs[5]  = '{"rd_after_wr",    1, 32'h8000_0010, 0, 32'h0,         32'h0,         4'h0, 1, 32'hFF22_FF44, 0};
        vecs[6]  = '{"wr_mask0",       1, 32'h8000_0010, 1, 32'h8000_0010, 32'hAABB_CCDD, 4'h0, 1, 32'hFF22_FF44, 0};
        vecs[7]  = '{"rd_lowbits",     1, 32'h8000_0013, 0, 32'h0,         32'h0,         4'h0, 1, 32'hFF22_FF44, 0};
        vecs[8]  = '{"rd_oor",         1, 32'h8000_4000, 0, 32'h0,         32'h0,         4'h0, 1, c_OOR_DATA,    c_OOR_ERR};
        vecs[9]  = '{"wr_oor",         0, 32'h0,         1, 32'h8000_4004, 32'h5566_7788, 4'hF, 0, 32'h0,         0};
        vecs[10] = '{"rd_w1",          1, 32'h8000_0004, 0, 32'h0,         32'h0,         4'h0, 1, c_W1_DATA,     0};
        vecs[11] = '{"wr_hi_byte",     0, 32'h0,         1, 32'h8000_0010, 32'h9900_0000, 4'h8, 0, 32'h0,         0};
        vecs[12] = '{"rd_hi_byte",     1, 32'h8000_0010, 0, 32'h0,         32'h0,         4'h0, 1, 32'h9922_FF44, 0};

        // Reset state
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_l0_rvalid", {31'b0, l0_rvalid}, 32'h0);
        chk("rst_l0_rdata", l0_rdata, 32'h0);
        chk("rst_l0_err", {31'b0, l0_err}, 32'h0);
        chk("rst_l0_cnt", l0_cnt, 32'h0);
        chk("rst_l3_rvalid", {31'b0, l3_rvalid}, 32'h0);
        chk("rst_l3_rdata", l3_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Table on the zero-latency instance
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rd, vecs[i].raddr, vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].wmask);
            #2;
            chk({vecs[i].name, "_rvalid"}, {31'b0, l0_rvalid}, {31'b0, vecs[i].exp_vld});
            chk({vecs[i].name, "_rdata"}, l0_rdata, vecs[i].exp_data);
            chk({vecs[i].name, "_err"}, {31'b0, l0_err}, {31'b0, vecs[i].exp_err});
            chk({vecs[i].name, "_cnt"}, l0_cnt, exp_cnt);
            if (vecs[i].rd) exp_cnt = exp_cnt + 32'd1;
            tick();
        end
        idle();
        chk("table_cnt_l3", l3_cnt, exp_cnt);

        // Pipelined reads: words A,B,C, with a store to word 0 while A is in flight
        drive(1'b0, '0, 1'b1, 32'h8000_0000, 32'hA0A0_A0A0, 4'hF); tick();
        drive(1'b0, '0, 1'b1, 32'h8000_0004, 32'hB1B1_B1B1, 4'hF); tick();
        drive(1'b0, '0, 1'b1, 32'h8000_0008, 32'hC2C2_C2C2, 4'hF); tick();
        idle(); tick();
        for (int k = 0; k < 7; k++) begin
            logic [31:0] exp3, exp2;
            case (k)
                0: drive(1'b1, 32'h8000_0000, 1'b0, '0, '0, 4'h0);
                1: drive(1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF);
                2: drive(1'b1, 32'h8000_0008, 1'b0, '0, '0, 4'h0);
                default: idle();
            endcase
            exp3 = (k == 3) ? 32'hA0A0_A0A0 : (k == 4) ? 32'hB1B1_B1B1 :
                   (k == 5) ? 32'hC2C2_C2C2 : 32'h0;
            exp2 = (k == 2) ? 32'hA0A0_A0A0 : (k == 3) ? 32'hB1B1_B1B1 :
                   (k == 4) ? 32'hC2C2_C2C2 : 32'h0;
            #2;
            chk($sformatf("l3_c%0d_rvalid", k), {31'b0, l3_rvalid}, {31'b0, (k >= 3 && k <= 5)});
            chk($sformatf("l3_c%0d_rdata", k), l3_rdata, exp3);
            chk($sformatf("l2_c%0d_rvalid", k), {31'b0, l2_rvalid}, {31'b0, (k >= 2 && k <= 4)});
            chk($sformatf("l2_c%0d_rdata", k), l2_rdata, exp2);
            if (k == 1) chk("l0_c1_rdata", l0_rdata, 32'hB1B1_B1B1);
            tick();
        end
        exp_cnt = exp_cnt + 32'd3;
        chk("pipe_cnt", l2_cnt, exp_cnt);

        // Reset with reads in flight and a store in the reset cycle
        drive(1'b1, 32'h8000_0000, 1'b0, '0, '0, 4'h0);
        tick();
        drive(1'b1, 32'h8000_0004, 1'b1, 32'h8000_0000, 32'hEEEE_EEEE, 4'hF);
        rst = 1'b1;
        #2;
        chk("rstmid_l2_rvalid", {31'b0, l2_rvalid}, 32'h0);
        chk("rstmid_cnt", l2_cnt, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        for (int k = 2; k < 6; k++) begin
            #2;
            chk($sformatf("rstmid_c%0d_l2_rvalid", k), {31'b0, l2_rvalid}, 32'h0);
            chk($sformatf("rstmid_c%0d_l3_rvalid", k), {31'b0, l3_rvalid}, 32'h0);
            tick();
        end
        exp_cnt = '0;
        chk("rstpost_cnt", l0_cnt, exp_cnt);
        drive(1'b1, 32'h8000_0000, 1'b0, '0, '0, 4'h0);
        #2;
        chk("rstpost_l0_rdata", l0_rdata, 32'h1234_5678);
        tick();
        idle();
        exp_cnt = exp_cnt + 32'd1;
        #2;
        chk("rstpost_l2_early", {31'b0, l2_rvalid}, 32'h0);
        tick();
        #2;
        chk("rstpost_l2_rvalid", {31'b0, l2_rvalid}, 32'h1);
        chk("rstpost_l2_rdata", l2_rdata, 32'h1234_5678);
        chk("rstpost_cnt1", l2_cnt, exp_cnt);
        tick();

        // Counter wrap
        u_l0.r_rd_cnt = 32'hFFFF_FFFE;
        drive(1'b1, 32'h8000_0000, 1'b0, '0, '0, 4'h0);
        tick();
        #2;
        chk("cnt_max", l0_cnt, 32'hFFFF_FFFF);
        tick();
        idle();
        #2;
        chk("cnt_wrap", l0_cnt, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
